// File: rtl/spi_txn_ctrl.sv
// SPI transaction controller: TX/RX byte FIFOs, engine start/done handshake, ss_n framing.
// Build option SPI_CTRL_RX_STALL_EN: hold off issuing bytes while the RX FIFO is full.

module spi_txn_ctrl #(
    parameter int TX_DEPTH  = 8,
    parameter int RX_DEPTH  = 8,
    parameter int SETUP_CYC = 4,
    parameter int GAP_CYC   = 2,
    parameter int HOLD_CYC  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tx_wr_en,
    input  logic [7:0]                  tx_wr_data,
    output logic                        tx_full,
    output logic [$clog2(TX_DEPTH):0]   tx_count,
    input  logic                        rx_rd_en,
    output logic [7:0]                  rx_rd_data,
    output logic                        rx_empty,
    output logic [$clog2(RX_DEPTH):0]   rx_count,
    output logic                        rx_overflow,
    input  logic                        ovf_clr,
    output logic                        busy,
    output logic                        spi_start,
    output logic [7:0]                  spi_tx_data,
    input  logic                        spi_ready,
    input  logic                        spi_done,
    input  logic [7:0]                  spi_rx_data,
    output logic                        ss_n
);

`ifdef SPI_CTRL_RX_STALL_EN
    localparam bit RxStall = 1'b1;
`else
    localparam bit RxStall = 1'b0;
`endif

    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ISSUE,
        S_WAIT,
        S_GAP,
        S_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        ss_n_q, ss_n_d;
    logic        start_q, start_d;
    logic [7:0]  txd_q, txd_d;
    logic        ovf_q, ovf_d;
    logic [TAW:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [RAW:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [7:0]  tx_mem [TX_DEPTH];
    logic [7:0]  rx_mem [RX_DEPTH];
    logic        tx_empty, rx_full;
    logic        tx_push, tx_pop, rx_push, rx_pop, ovf_set;

    assign tx_count = tx_wp_q - tx_rp_q;
    assign rx_count = rx_wp_q - rx_rp_q;
    assign tx_full  = (tx_count == (TAW+1)'(TX_DEPTH));
    assign tx_empty = (tx_count == '0);
    assign rx_full  = (rx_count == (RAW+1)'(RX_DEPTH));
    assign rx_empty = (rx_count == '0);

    // Fullness is judged before any same-cycle pop, on both FIFOs.
    assign tx_push = tx_wr_en && !tx_full;
    assign rx_pop  = rx_rd_en && !rx_empty;
    assign rx_rd_data = rx_empty ? 8'h00 : rx_mem[rx_rp_q[RAW-1:0]];

    always_comb begin
        tx_wp_d = tx_wp_q + {{TAW{1'b0}}, tx_push};
        tx_rp_d = tx_rp_q + {{TAW{1'b0}}, tx_pop};
        rx_wp_d = rx_wp_q + {{RAW{1'b0}}, rx_push};
        rx_rp_d = rx_rp_q + {{RAW{1'b0}}, rx_pop};
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp_q[TAW-1:0]] <= tx_wr_data;
        if (rx_push) rx_mem[rx_wp_q[RAW-1:0]] <= spi_rx_data;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ss_n_d  = ss_n_q;
        start_d = 1'b0;
        txd_d   = txd_q;
        tx_pop  = 1'b0;
        rx_push = 1'b0;
        ovf_set = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                ss_n_d = 1'b1;
                if (!tx_empty) begin
                    state_d = S_SETUP;
                    ss_n_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_SETUP: begin
                if (cnt_q == 16'(SETUP_CYC - 1)) state_d = S_ISSUE;
                else cnt_d = cnt_q + 16'd1;
            end
            S_ISSUE: begin
                if (spi_ready && !tx_empty && !(RxStall && rx_full)) begin
                    start_d = 1'b1;
                    txd_d   = tx_mem[tx_rp_q[TAW-1:0]];
                    tx_pop  = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (spi_done) begin
                    if (!rx_full) rx_push = 1'b1;
                    else ovf_set = !RxStall;
                    cnt_d = '0;
                    if (tx_empty) state_d = S_HOLD;
                    else if (GAP_CYC == 0) state_d = S_ISSUE;
                    else state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt_q == 16'(GAP_CYC - 1)) state_d = S_ISSUE;
                else cnt_d = cnt_q + 16'd1;
            end
            S_HOLD: begin
                if (cnt_q == 16'(HOLD_CYC - 1)) begin
                    state_d = S_IDLE;
                    ss_n_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                ss_n_d  = 1'b1;
            end
        endcase
        ovf_d = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ss_n_q  <= 1'b1;
            start_q <= 1'b0;
            txd_q   <= '0;
            ovf_q   <= 1'b0;
            tx_wp_q <= '0;
            tx_rp_q <= '0;
            rx_wp_q <= '0;
            rx_rp_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ss_n_q  <= ss_n_d;
            start_q <= start_d;
            txd_q   <= txd_d;
            ovf_q   <= ovf_d;
            tx_wp_q <= tx_wp_d;
            tx_rp_q <= tx_rp_d;
            rx_wp_q <= rx_wp_d;
            rx_rp_q <= rx_rp_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign spi_start   = start_q;
    assign spi_tx_data = txd_q;
    assign ss_n        = ss_n_q;
    assign rx_overflow = ovf_q;

endmodule

// File: tb/tb_spi_txn_ctrl.sv
// Directed bench for spi_txn_ctrl with a loopback SPI engine model.
// Checks framing deltas, FIFO limits, overflow, reset and pointer wrap.

module tb_spi_txn_ctrl;
    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_wr_en = 1'b0;
    logic [7:0] tx_wr_data = 8'h00;
    logic       tx_full;
    logic [3:0] tx_count;
    logic       rx_rd_en = 1'b0;
    logic [7:0] rx_rd_data;
    logic       rx_empty;
    logic [3:0] rx_count;
    logic       rx_overflow;
    logic       ovf_clr = 1'b0;
    logic       busy;
    logic       spi_start;
    logic [7:0] spi_tx_data;
    logic       spi_ready = 1'b0;
    logic       spi_done = 1'b0;
    logic [7:0] spi_rx_data = 8'h00;
    logic       ss_n;

    spi_txn_ctrl dut (
        .clk(clk), .rst(rst),
        .tx_wr_en(tx_wr_en), .tx_wr_data(tx_wr_data),
        .tx_full(tx_full), .tx_count(tx_count),
        .rx_rd_en(rx_rd_en), .rx_rd_data(rx_rd_data),
        .rx_empty(rx_empty), .rx_count(rx_count),
        .rx_overflow(rx_overflow), .ovf_clr(ovf_clr),
        .busy(busy), .spi_start(spi_start), .spi_tx_data(spi_tx_data),
        .spi_ready(spi_ready), .spi_done(spi_done),
        .spi_rx_data(spi_rx_data), .ss_n(ss_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Engine model: loopback, done LAT+1 cycles after start is seen
    logic       eng_hold = 1'b0;
    logic       eng_busy = 1'b0;
    int         eng_cnt = 0;
    logic [7:0] eng_data = 8'h00;
    int         ndone = 0;
    int         done_cyc [64];

    always @(negedge clk) begin
        if (rst) begin
            eng_busy  <= 1'b0;
            eng_cnt   <= 0;
            spi_done  <= 1'b0;
            spi_ready <= 1'b0;
        end else begin
            spi_done <= 1'b0;
            if (eng_busy) begin
                if (eng_cnt == 0) begin
                    spi_done    <= 1'b1;
                    spi_rx_data <= eng_data;
                    eng_busy    <= 1'b0;
                    spi_ready   <= !eng_hold;
                    done_cyc[ndone % 64] <= cyc;
                    ndone <= ndone + 1;
                end else begin
                    eng_cnt   <= eng_cnt - 1;
                    spi_ready <= 1'b0;
                end
            end else if (spi_start) begin
                eng_busy  <= 1'b1;
                eng_data  <= spi_tx_data;
                eng_cnt   <= LAT;
                spi_ready <= 1'b0;
            end else begin
                spi_ready <= !eng_hold;
            end
        end
    end

    logic       prev_ss = 1'b1;
    int         nstart = 0, nfall = 0, nrise = 0;
    int         start_cyc [64];
    logic [7:0] start_dat [64];
    int         fall_cyc [64];
    int         rise_cyc [64];

    always @(negedge clk) begin
        prev_ss <= ss_n;
        if (prev_ss && !ss_n) begin
            fall_cyc[nfall % 64] <= cyc;
            nfall <= nfall + 1;
        end
        if (!prev_ss && ss_n) begin
            rise_cyc[nrise % 64] <= cyc;
            nrise <= nrise + 1;
        end
        if (spi_start) begin
            start_cyc[nstart % 64] <= cyc;
            start_dat[nstart % 64] <= spi_tx_data;
            nstart <= nstart + 1;
        end
    end

    int nchk = 0;
    int nerr = 0;
    int s0, d0, f0, r0;

    task automatic check(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task mark();
        s0 = nstart;
        d0 = ndone;
        f0 = nfall;
        r0 = nrise;
    endtask

    task push(input logic [7:0] d);
        @(negedge clk);
        tx_wr_en = 1'b1;
        tx_wr_data = d;
    endtask

    task push_end();
        @(negedge clk);
        tx_wr_en = 1'b0;
    endtask

    task pop_check(input string nm, input logic [7:0] exp);
        @(negedge clk);
        check(nm, int'(rx_rd_data), int'(exp));
        rx_rd_en = 1'b1;
        @(negedge clk);
        rx_rd_en = 1'b0;
    endtask

    task wait_idle(input string nm, input int budget);
        int k;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!((nrise > r0) && !busy && ss_n) && k < budget);
        if (k >= budget) begin
            nchk++;
            nerr++;
            $display("FAIL %s: timeout after %0d cycles", nm, budget);
        end
    endtask

    typedef struct {
        int              n;
        logic [2:0][7:0] d;
        int              lead;
        int              gap;
        int              hold;
    } vec_t;

    vec_t tbl [4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0].n = 1; tbl[0].d = {8'h00, 8'h00, 8'hA5};
        tbl[1].n = 3; tbl[1].d = {8'h33, 8'h22, 8'h11};
        tbl[2].n = 2; tbl[2].d = {8'h00, 8'hFF, 8'h00};
        tbl[3].n = 3; tbl[3].d = {8'h7E, 8'hC3, 8'h5A};
        for (int v = 0; v < 4; v++) begin
            tbl[v].lead = 5;
            tbl[v].gap  = 4;
            tbl[v].hold = 5;
        end

        repeat (3) @(posedge clk);
        #1;
        check("rst_ss_n", int'(ss_n), 1);
        check("rst_start", int'(spi_start), 0);
        check("rst_txdata", int'(spi_tx_data), 0);
        check("rst_ovf", int'(rx_overflow), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_tx_full", int'(tx_full), 0);
        check("rst_rx_empty", int'(rx_empty), 1);
        check("rst_tx_count", int'(tx_count), 0);
        check("rst_rx_count", int'(rx_count), 0);
        check("rst_rx_data", int'(rx_rd_data), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            mark();
            for (int i = 0; i < tbl[v].n; i++) push(tbl[v].d[i]);
            push_end();
            wait_idle($sformatf("v%0d_wait", v), 200);
            check($sformatf("v%0d_frames", v), nfall - f0, 1);
            check($sformatf("v%0d_starts", v), nstart - s0, tbl[v].n);
            check($sformatf("v%0d_lead", v),
                  start_cyc[s0 % 64] - fall_cyc[f0 % 64], tbl[v].lead);
            for (int i = 0; i < tbl[v].n; i++) begin
                check($sformatf("v%0d_mosi%0d", v, i),
                      int'(start_dat[(s0 + i) % 64]), int'(tbl[v].d[i]));
                if (i > 0)
                    check($sformatf("v%0d_gap%0d", v, i),
                          start_cyc[(s0 + i) % 64] - done_cyc[(d0 + i - 1) % 64],
                          tbl[v].gap);
            end
            check($sformatf("v%0d_hold", v),
                  rise_cyc[r0 % 64] - done_cyc[(d0 + tbl[v].n - 1) % 64], tbl[v].hold);
            check($sformatf("v%0d_rx_count", v), int'(rx_count), tbl[v].n);
            check($sformatf("v%0d_busy", v), int'(busy), 0);
            for (int i = 0; i < tbl[v].n; i++)
                pop_check($sformatf("v%0d_rx%0d", v, i), tbl[v].d[i]);
            check($sformatf("v%0d_rx_empty", v), int'(rx_empty), 1);
        end

        // TX full with engine stalled
        eng_hold = 1'b1;
        repeat (3) @(negedge clk);
        mark();
        for (int i = 0; i < 9; i++) push(8'h40 + 8'(i));
        push_end();
        repeat (3) @(negedge clk);
        check("txf_full", int'(tx_full), 1);
        check("txf_count", int'(tx_count), 8);
        check("txf_busy", int'(busy), 1);
        check("txf_nostart", nstart - s0, 0);
        eng_hold = 1'b0;
        wait_idle("txf_wait", 400);
        check("txf_starts", nstart - s0, 8);
        check("txf_frames", nfall - f0, 1);
        for (int i = 0; i < 8; i++)
            check($sformatf("txf_mosi%0d", i), int'(start_dat[(s0 + i) % 64]), 'h40 + i);
        check("txf_rx_count", int'(rx_count), 8);
        check("txf_ovf", int'(rx_overflow), 0);

        // One more byte while RX is full
        mark();
        push(8'h99);
        push_end();
`ifndef SPI_CTRL_RX_STALL_EN
        wait_idle("rxf_wait", 100);
        check("rxf_starts", nstart - s0, 1);
        check("rxf_ovf_set", int'(rx_overflow), 1);
        check("rxf_count", int'(rx_count), 8);
        for (int i = 0; i < 8; i++)
            pop_check($sformatf("rxf_rx%0d", i), 8'h40 + 8'(i));
        check("rxf_empty", int'(rx_empty), 1);
        check("rxf_ovf_sticky", int'(rx_overflow), 1);
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("rxf_ovf_clr", int'(rx_overflow), 0);
`else
        repeat (30) @(negedge clk);
        check("rxs_nostart", nstart - s0, 0);
        check("rxs_ss_low", int'(ss_n), 0);
        check("rxs_busy", int'(busy), 1);
        pop_check("rxs_rx0", 8'h40);
        wait_idle("rxs_wait", 100);
        check("rxs_starts", nstart - s0, 1);
        check("rxs_ovf", int'(rx_overflow), 0);
        for (int i = 1; i < 8; i++)
            pop_check($sformatf("rxs_rx%0d", i), 8'h40 + 8'(i));
        pop_check("rxs_rx8", 8'h99);
        check("rxs_empty", int'(rx_empty), 1);
`endif

        // Reset during byte 2 of 3
        mark();
        push(8'h01);
        push(8'h02);
        push(8'h03);
        push_end();
        begin
            int k;
            k = 0;
            do begin
                @(posedge clk);
                #1;
                k++;
            end while ((nstart - s0) < 2 && k < 200);
            check("rstm_reached", int'(k < 200), 1);
        end
        check("rstm_pre_ss", int'(ss_n), 0);
        check("rstm_pre_tx", int'(tx_count), 1);
        rst = 1'b1;
        #1;
        check("rstm_ss_n", int'(ss_n), 1);
        check("rstm_start", int'(spi_start), 0);
        check("rstm_tx_count", int'(tx_count), 0);
        check("rstm_rx_count", int'(rx_count), 0);
        check("rstm_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mark();
        repeat (40) @(negedge clk);
        check("rstm_nostart", nstart - s0, 0);
        check("rstm_noframe", nfall - f0, 0);
        check("rstm_ss_idle", int'(ss_n), 1);

        // 20 single-byte transfers across pointer wrap
        for (int i = 0; i < 20; i++) begin
            logic [7:0] b;
            b = 8'(i * 13 + 7);
            mark();
            push(b);
            push_end();
            wait_idle($sformatf("wrap%0d_wait", i), 100);
            check($sformatf("wrap%0d_rx_count", i), int'(rx_count), 1);
            check($sformatf("wrap%0d_tx_count", i), int'(tx_count), 0);
            pop_check($sformatf("wrap%0d_rx", i), b);
        end

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
